// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: per-requester byte FIFOs feeding one UART transmitter.
// Requesters are served round-robin. An optional line lock keeps one
// requester's text line unbroken until it sends a newline. The transmitter
// is driven with a registered valid strobe. A byte starts on each rising
// edge of valid while the transmitter reports ready.
module uart_tx_arbiter #(
    parameter int  NUM_REQ  = 2,
    parameter int  DEPTH    = 16,
    parameter int  LOCK_NL  = 1,
    parameter int  LOCK_TMO = 4096,
    localparam int OW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic                 busy_o,
    output logic                 lock_o,
    output logic [OW-1:0]        owner_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [15:0] TMO_LAST = 16'(LOCK_TMO - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, DRAIN} state_e;

    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] empty;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] elig;
    logic [7:0]         head [NUM_REQ];

    state_e      state_q, state_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [OW-1:0] owner_q, owner_d;
    logic        lock_q, lock_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    logic          found;
    logic [OW-1:0] win;
    logic          launch;

    // One FIFO per requester. The extra pointer bit separates full from empty.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
        logic [7:0]  mem [DEPTH];
        logic [AW:0] wptr_q, wptr_d;
        logic [AW:0] rptr_q, rptr_d;
        logic        push;

        assign full[gi]  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        assign empty[gi] = (wptr_q == rptr_q);
        // Fullness comes from the registered pointers only. A pop in this
        // cycle does not let a push into a full FIFO through.
        assign push      = req_valid_i[gi] && !full[gi];
        assign head[gi]  = mem[rptr_q[AW-1:0]];

        // Pointer advance on push / pop
        always_comb begin
            wptr_d = wptr_q + {{AW{1'b0}}, push};
            rptr_d = rptr_q + {{AW{1'b0}}, pop[gi]};
        end

        // Pointer registers; reset empties the FIFO
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
            end
        end

        // Storage write; contents need no reset because the pointers gate them
        always_ff @(posedge clk_i) begin
            if (push) begin
                mem[wptr_q[AW-1:0]] <= req_data_i[8*gi +: 8];
            end
        end
    end

    assign req_ready_o = ~full;

    // Eligibility and rotating search, starting after the last owner
    always_comb begin
        int idx;
        found = 1'b0;
        win   = owner_q;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = !empty[i] && (!lock_q || (owner_q == OW'(i)));
        end
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(owner_q) + off) % NUM_REQ;
            if (!found && elig[OW'(idx)]) begin
                found = 1'b1;
                win   = OW'(idx);
            end
        end
    end

    assign launch = (state_q == IDLE) && tx_ready_i && found;

    // Pop the winning FIFO on the launch edge
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pop[i] = launch && (win == OW'(i));
        end
    end

    // Next state: launch/drain sequencing, lock tracking and lock timeout
    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        tmo_cnt_d  = '0;

        // A held lock whose owner has gone quiet is released eventually.
        // Launch and timeout cannot coincide: under lock, a launch needs a
        // non-empty owner FIFO.
        if (lock_q && (state_q == IDLE) && empty[owner_q]) begin
            if (tmo_cnt_q == TMO_LAST) begin
                lock_d    = 1'b0;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (launch) begin
                    tx_data_d  = head[win];
                    tx_valid_d = 1'b1;
                    owner_d    = win;
                    state_d    = LAUNCH;
                    if (LOCK_NL != 0) begin
                        lock_d = (head[win] != 8'h0A);
                    end
                end
            end
            LAUNCH: begin
                // The transmitter has taken the byte once it drops ready
                if (!tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (tx_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            owner_q    <= OW'(NUM_REQ - 1);
            lock_q     <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign owner_o    = owner_q;
    assign lock_o     = lock_q;
    assign busy_o     = (state_q != IDLE) || !(&empty);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: instance 0 has the line lock, instance 1 runs
// plain round-robin. Both use DEPTH=4 and LOCK_TMO=16. A small transmitter
// model answers each launch.
module tb_uart_tx_arbiter;

    localparam int FRAME = 6;

    typedef struct packed {
        logic [7:0] data;
        logic       owner;
        logic       lock;
    } exp_t;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_ni;
    logic [15:0] req_data  [2];
    logic [1:0]  req_valid [2];
    logic [1:0]  req_ready [2];
    logic [7:0]  tx_data   [2];
    logic        tx_valid  [2];
    logic        tx_ready  [2];
    logic        busy      [2];
    logic        lock      [2];
    logic        owner     [2];
    logic        hold      [2];

    // Transmitter model state
    logic        m_rdy  [2];
    logic        pend   [2];
    int          m_cnt  [2];
    logic        vprev  [2];
    int          hi_cnt [2];
    logic [7:0]  held   [2];

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        uart_tx_arbiter #(
            .NUM_REQ (2),
            .DEPTH   (4),
            .LOCK_NL ((gi == 0) ? 1 : 0),
            .LOCK_TMO(16)
        ) u_dut (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .req_data_i (req_data[gi]),
            .req_valid_i(req_valid[gi]),
            .req_ready_o(req_ready[gi]),
            .tx_data_o  (tx_data[gi]),
            .tx_valid_o (tx_valid[gi]),
            .tx_ready_i (tx_ready[gi]),
            .busy_o     (busy[gi]),
            .lock_o     (lock[gi]),
            .owner_o    (owner[gi])
        );
        assign tx_ready[gi] = m_rdy[gi] & ~hold[gi];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter model and launch monitor. The model behaves like a
    // posedge-sampling transmitter: ready falls one cycle after it sees the
    // valid rise, then stays low for FRAME cycles.
    always @(negedge clk_i) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_ni) begin
                m_rdy[k]  = 1'b1;
                pend[k]   = 1'b0;
                m_cnt[k]  = 0;
                vprev[k]  = 1'b0;
                hi_cnt[k] = 0;
            end else begin
                if (pend[k]) begin
                    m_rdy[k] = 1'b0;
                    m_cnt[k] = FRAME;
                    pend[k]  = 1'b0;
                end else if (m_cnt[k] > 0) begin
                    m_cnt[k]--;
                    if (m_cnt[k] == 0) m_rdy[k] = 1'b1;
                end
                if (tx_valid[k] && !vprev[k]) begin
                    $display("tx dut%0d byte %02h owner %0d lock %0d", k, tx_data[k], owner[k], lock[k]);
                    if (exp_q.size() == 0) begin
                        check_val("spurious_launch", 32'(tx_data[k]), 32'h100);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check_val("tx_data", 32'(tx_data[k]), 32'(mon_e.data));
                        check_val("owner", 32'(owner[k]), 32'(mon_e.owner));
                        check_val("lock", 32'(lock[k]), 32'(mon_e.lock));
                    end
                    pend[k]   = 1'b1;
                    held[k]   = tx_data[k];
                    hi_cnt[k] = 1;
                end else if (tx_valid[k]) begin
                    hi_cnt[k]++;
                    check_val("data_stable", 32'(tx_data[k]), 32'(held[k]));
                end else if (vprev[k]) begin
                    check_val("valid_width", 32'(hi_cnt[k]), 32'd2);
                end
                vprev[k] = tx_valid[k];
            end
        end
    end

    task automatic push2(input int k, input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
        @(negedge clk_i);
        req_data[k]  = {d1, d0};
        req_valid[k] = v;
        @(posedge clk_i);
        #1;
        req_valid[k] = 2'b00;
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic o, input logic l);
        exp_t e;
        e.data  = d;
        e.owner = o;
        e.lock  = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int k);
        int c;
        c = 0;
        while (busy[k] && c < 500) begin
            @(negedge clk_i);
            c++;
        end
        check_val("idle_reached", 32'(busy[k]), 32'd0);
        check_val("drain_ready", 32'(tx_ready[k]), 32'd1);
        check_val("all_sent", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int c;
        rst_ni       = 1'b0;
        hold[0]      = 1'b0;
        hold[1]      = 1'b0;
        req_valid[0] = 2'b00;
        req_valid[1] = 2'b00;
        req_data[0]  = 16'h0;
        req_data[1]  = 16'h0;
        repeat (3) @(negedge clk_i);
        for (int k = 0; k < 2; k++) begin
            check_val("ready_in_reset", 32'(req_ready[k]), 32'h3);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        for (int k = 0; k < 2; k++) begin
            check_val("rst_valid", 32'(tx_valid[k]), 32'd0);
            check_val("rst_data", 32'(tx_data[k]), 32'h00);
            check_val("rst_lock", 32'(lock[k]), 32'd0);
            check_val("rst_owner", 32'(owner[k]), 32'd1);
            check_val("rst_busy", 32'(busy[k]), 32'd0);
            check_val("rst_ready", 32'(req_ready[k]), 32'h3);
        end

        // Round-robin without lock
        expect_byte(8'h30, 1'b0, 1'b0);
        expect_byte(8'h40, 1'b1, 1'b0);
        expect_byte(8'h31, 1'b0, 1'b0);
        expect_byte(8'h41, 1'b1, 1'b0);
        push2(1, 2'b11, 8'h30, 8'h40);
        push2(1, 2'b11, 8'h31, 8'h41);
        wait_idle(1);

        // Single byte
        expect_byte(8'h41, 1'b0, 1'b0);
        push2(1, 2'b01, 8'h41, 8'h00);
        wait_idle(1);

        // Line lock: two lines queued together stay unbroken
        expect_byte("A", 1'b0, 1'b1);
        expect_byte("B", 1'b0, 1'b1);
        expect_byte(8'h0A, 1'b0, 1'b0);
        expect_byte("x", 1'b1, 1'b1);
        expect_byte("y", 1'b1, 1'b1);
        expect_byte(8'h0A, 1'b1, 1'b0);
        push2(0, 2'b11, "A", "x");
        push2(0, 2'b11, "B", "y");
        push2(0, 2'b11, 8'h0A, 8'h0A);
        wait_idle(0);

        // Lock timeout: unterminated line blocks req 1 until force-release
        expect_byte("A", 1'b0, 1'b1);
        expect_byte("z", 1'b1, 1'b1);
        push2(0, 2'b01, "A", 8'h00);
        push2(0, 2'b10, 8'h00, "z");
        repeat (12) @(negedge clk_i);
        check_val("lock_held", 32'(lock[0]), 32'd1);
        check_val("z_blocked", 32'(exp_q.size()), 32'd1);
        c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            @(negedge clk_i);
            c++;
        end
        check_val("tmo_window", 32'((c >= 12) && (c <= 16)), 32'd1);
        wait_idle(0);

        // Backpressure: FIFO of 4 fills while the transmitter stays busy
        hold[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            req_data[0]  = {8'h00, 8'(8'h61 + i)};
            req_valid[0] = 2'b01;
            check_val("bp_ready", 32'(req_ready[0][0]), 32'(i < 4));
            if (i < 4) expect_byte(8'(8'h61 + i), 1'b0, 1'b1);
        end
        @(negedge clk_i);
        req_valid[0] = 2'b00;
        repeat (30) @(negedge clk_i);
        hold[0] = 1'b0;
        wait_idle(0);

        // Reset during LAUNCH with three bytes still queued
        hold[0] = 1'b1;
        expect_byte(8'h71, 1'b0, 1'b1);
        push2(0, 2'b01, 8'h71, 8'h00);
        push2(0, 2'b01, 8'h72, 8'h00);
        push2(0, 2'b01, 8'h73, 8'h00);
        push2(0, 2'b01, 8'h74, 8'h00);
        hold[0] = 1'b0;
        c = 0;
        while (c < 50) begin
            @(posedge clk_i);
            #1;
            if (tx_valid[0]) break;
            c++;
        end
        check_val("launch_seen", 32'(tx_valid[0]), 32'd1);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check_val("rst_mid_valid", 32'(tx_valid[0]), 32'd0);
        check_val("rst_mid_ready", 32'(req_ready[0]), 32'h3);
        check_val("rst_mid_lock", 32'(lock[0]), 32'd0);
        check_val("rst_mid_busy", 32'(busy[0]), 32'd0);
        repeat (2) @(negedge clk_i);
        #2;
        rst_ni = 1'b1;
        repeat (20) @(negedge clk_i);
        check_val("post_rst_ready", 32'(req_ready[0]), 32'h3);
        check_val("post_rst_busy", 32'(busy[0]), 32'd0);
        check_val("post_rst_owner", 32'(owner[0]), 32'd1);
        check_val("post_rst_queue", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
